// File: rtl/crossword_pkg.sv
// Shared keyboard constants and typematic state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package crossword_pkg;

  // USB HID usage codes seen on the raw keycode path
  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_UP    = 8'h52;

  // Letters 'a'..'z'
  localparam logic [7:0] KEY_LETTER_MIN = 8'h04;
  localparam logic [7:0] KEY_LETTER_MAX = 8'h1D;

  typedef enum logic [1:0] {
    TM_IDLE    = 2'd0,
    TM_DELAY   = 2'd1,
    TM_REPEAT  = 2'd2,
    TM_LOCKOUT = 2'd3
  } tm_state_e;

endpackage

// File: rtl/keycode_typematic_if.sv
// Keycode request/event bundle between the keyboard path and the typematic block.
// Latency: n/a (wiring only).
// Backpressure: none; events are single-cycle pulses that consumers must take.
interface keycode_typematic_if;
  logic [7:0] keycode_in;
  logic       enable;
  logic [7:0] keycode_out;
  logic       key_valid;
  logic       is_repeat;

  // Driver of raw keycodes / consumer of events
  modport master (
    output keycode_in, enable,
    input  keycode_out, key_valid, is_repeat
  );

  // The typematic block itself
  modport slave (
    input  keycode_in, enable,
    output keycode_out, key_valid, is_repeat
  );
endinterface

// File: rtl/keycode_typematic.sv
// Converts a held raw keycode into one press event plus timed typematic repeats.
// Latency: event registered at the edge that samples the key (1 frame).
// Backpressure: none; each event is a one-frame pulse, no stalling possible.
module keycode_typematic
  import crossword_pkg::*;
#(
  parameter int DELAY_FRAMES  = 30,
  parameter int REPEAT_FRAMES = 6,
  parameter int CNT_W         = 8
) (
  input  logic                frame_clk,
  input  logic                Reset_n,
  keycode_typematic_if.slave  kb
);

  localparam logic [1:0] ST_IDLE    = TM_IDLE;
  localparam logic [1:0] ST_DELAY   = TM_DELAY;
  localparam logic [1:0] ST_REPEAT  = TM_REPEAT;
  localparam logic [1:0] ST_LOCKOUT = TM_LOCKOUT;

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_FRAMES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_FRAMES - 1);

  logic [1:0]       r_state;
  logic [7:0]       r_held;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_kc;
  logic             r_vld;
  logic             r_rep;

  logic [1:0]       w_state;
  logic [7:0]       w_held;
  logic [CNT_W-1:0] w_cnt;
  logic [7:0]       w_kc;
  logic             w_rep;
  logic [CNT_W-1:0] w_last;

  // Next-state and event decision; enable drop overrides everything else
  always_comb begin
    w_state = r_state;
    w_held  = r_held;
    w_cnt   = r_cnt;
    w_kc    = KEY_NONE;
    w_rep   = 1'b0;
    w_last  = (r_state == ST_DELAY) ? DLY_LAST : RPT_LAST;

    if (!kb.enable) begin
      w_state = ST_LOCKOUT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (kb.keycode_in != KEY_NONE) begin
            w_kc    = kb.keycode_in;
            w_held  = kb.keycode_in;
            w_cnt   = '0;
            w_state = ST_DELAY;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (kb.keycode_in == KEY_NONE) begin
            w_state = ST_IDLE;
          end else if (kb.keycode_in != r_held) begin
            // Rollover to a new key restarts the full initial delay
            w_kc    = kb.keycode_in;
            w_held  = kb.keycode_in;
            w_cnt   = '0;
            w_state = ST_DELAY;
          end else if (r_cnt == w_last) begin
            w_kc    = r_held;
            w_rep   = 1'b1;
            w_cnt   = '0;
            w_state = ST_REPEAT;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        default: begin
          // Lockout: a key held across the enable drop must be released first
          if (kb.keycode_in == KEY_NONE) w_state = ST_IDLE;
        end
      endcase
    end
  end

  // State, tracked key, frame counter and registered event outputs
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_held  <= KEY_NONE;
      r_cnt   <= '0;
      r_kc    <= KEY_NONE;
      r_vld   <= 1'b0;
      r_rep   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_held  <= w_held;
      r_cnt   <= w_cnt;
      r_kc    <= w_kc;
      r_vld   <= (w_kc != KEY_NONE);
      r_rep   <= w_rep;
    end
  end

  assign kb.keycode_out = r_kc;
  assign kb.key_valid   = r_vld;
  assign kb.is_repeat   = r_rep;

endmodule
